// File: rtl/logic_healthcare_system_if.sv
// ---------------------------------------------------------------------------
// logic_healthcare_system_if
//
// Outbound-link bundle of the patient monitor: load strobe, request/confirm
// handshake, the data/key pair to encrypt and the two 7-bit report words.
//
//   request    1  ask for transmission of the loaded record
//   confirm    1  receiver acknowledges the presented report
//   inputdata  1  load strobe for data/key
//   key        8  encryption key
//   data       8  payload to encrypt
//   dataP      7  report word P
//   dataQ      7  report word Q
//
// master : the side driving the handshake (link controller / bench)
// slave  : the monitor block itself
// ---------------------------------------------------------------------------
interface logic_healthcare_system_if;
  logic       request;
  logic       confirm;
  logic       inputdata;
  logic [7:0] key;
  logic [7:0] data;
  logic [6:0] dataP;
  logic [6:0] dataQ;

  modport master (
    output request, confirm, inputdata, key, data,
    input  dataP, dataQ
  );

  modport slave (
    input  request, confirm, inputdata, key, data,
    output dataP, dataQ
  );
endinterface

// File: rtl/logic_healthcare_system.sv
// ---------------------------------------------------------------------------
// logic_healthcare_system
//
// Patient-monitoring block. Every cycle it classifies the current sensor
// readings into a 6-bit abnormality vector and its popcount, both registered.
// Independently, a three-state FSM loads a data/key pair, and on request
// presents an XOR-encrypted 14-bit report on dataP/dataQ until confirmed.
//
// Ports:
//   clock            1  rising-edge system clock
//   reset            1  synchronous, active-high reset
//   link             -  handshake + data/key + report words (slave side)
//   pressureData     6  blood pressure reading
//   bloodPH          4  blood pH code
//   bloodType        3  blood type code (report only)
//   fdSensorValue    8  fall-detector reading
//   fdFactoryValue   8  fall-detector threshold
//   factoryBaseTemp  8  temperature calibration offset
//   factoryTempCoef  4  temperature calibration gain
//   tempSensorValue  4  raw temperature sensor code
//   abnormaliryWarning 3  number of set bits in abnormaliryVector
//   abnormaliryVector  6  {p_high, p_low, ph_bad, fall, fever, hypothermia}
// ---------------------------------------------------------------------------
module logic_healthcare_system (
  input  logic                             clock,
  input  logic                             reset,
  logic_healthcare_system_if.slave         link,
  input  logic [5:0]                       pressureData,
  input  logic [3:0]                       bloodPH,
  input  logic [2:0]                       bloodType,
  input  logic [7:0]                       fdSensorValue,
  input  logic [7:0]                       fdFactoryValue,
  input  logic [7:0]                       factoryBaseTemp,
  input  logic [3:0]                       factoryTempCoef,
  input  logic [3:0]                       tempSensorValue,
  output logic [2:0]                       abnormaliryWarning,
  output logic [5:0]                       abnormaliryVector
);

  typedef enum logic [1:0] {
    IDLE,
    LOADED,
    SEND
  } state_t;

  function automatic logic [2:0] popcount6(input logic [5:0] v);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < 6; i++) n = n + 3'(v[i]);
    return n;
  endfunction

  // -------------------------------------------------------------------------
  // Sensor classification
  // -------------------------------------------------------------------------
  logic [7:0] temp_prod;
  logic [8:0] temp_c;
  logic [5:0] vector_c;
  logic [2:0] warning_c;

  // Full 9-bit sum: 255 + 15*15 = 480 must not wrap, or a very hot reading
  // would alias into the hypothermia range.
  assign temp_prod = {4'd0, factoryTempCoef} * {4'd0, tempSensorValue};
  assign temp_c    = {1'b0, factoryBaseTemp} + {1'b0, temp_prod};

  assign vector_c[5] = pressureData > 6'd45;
  assign vector_c[4] = pressureData < 6'd20;
  assign vector_c[3] = (bloodPH < 4'd6) || (bloodPH > 4'd8);
  assign vector_c[2] = fdSensorValue > fdFactoryValue;
  assign vector_c[1] = temp_c > 9'd38;
  assign vector_c[0] = temp_c < 9'd35;

  // Warning is taken from the combinational vector so both update together.
  assign warning_c = popcount6(vector_c);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      abnormaliryVector  <= '0;
      abnormaliryWarning <= '0;
    end else begin
      abnormaliryVector  <= vector_c;
      abnormaliryWarning <= warning_c;
    end
  end

  // -------------------------------------------------------------------------
  // Report FSM
  // -------------------------------------------------------------------------
  state_t     state_q, state_d;
  logic [7:0] data_q, data_d;
  logic [7:0] key_q, key_d;
  logic [6:0] p_q, p_d;
  logic [6:0] q_q, q_d;
  logic [7:0] enc;

  assign enc = data_q ^ key_q;

  // NOTE: every signal driven here gets a hold/default value first, so no
  // path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    key_d   = key_q;
    p_d     = p_q;
    q_d     = q_q;

    unique case (state_q)
      IDLE: begin
        if (link.inputdata) begin
          data_d  = link.data;
          key_d   = link.key;
          state_d = LOADED;
        end
      end

      LOADED: begin
        // request outranks a simultaneous load: the stored pair is encrypted.
        if (link.request) begin
          p_d     = enc[6:0];
          q_d     = {enc[7], bloodType, warning_c};
          state_d = SEND;
        end else if (link.inputdata) begin
          data_d = link.data;
          key_d  = link.key;
        end
      end

      SEND: begin
        if (link.confirm) begin
          p_d     = '0;
          q_d     = '0;
          data_d  = '0;
          key_d   = '0;
          state_d = IDLE;
        end
      end

      default: begin
        p_d     = '0;
        q_d     = '0;
        data_d  = '0;
        key_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: reset is synchronous, so it only takes effect on a clock edge and
  // all inputs presented in that cycle are discarded.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      data_q  <= '0;
      key_q   <= '0;
      p_q     <= '0;
      q_q     <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      key_q   <= key_d;
      p_q     <= p_d;
      q_q     <= q_d;
    end
  end

  assign link.dataP = p_q;
  assign link.dataQ = q_q;

endmodule

// File: tb/tb_logic_healthcare_system.sv
// ---------------------------------------------------------------------------
// tb_logic_healthcare_system
//
// Directed-vector bench for logic_healthcare_system. Inputs change 1 time
// unit after a rising edge; outputs are compared at the same point, i.e.
// after the edge that registered them.
// ---------------------------------------------------------------------------
module tb_logic_healthcare_system;

  logic       clock;
  logic       reset;
  logic [5:0] pressureData;
  logic [3:0] bloodPH;
  logic [2:0] bloodType;
  logic [7:0] fdSensorValue;
  logic [7:0] fdFactoryValue;
  logic [7:0] factoryBaseTemp;
  logic [3:0] factoryTempCoef;
  logic [3:0] tempSensorValue;
  logic [2:0] abnormaliryWarning;
  logic [5:0] abnormaliryVector;

  int checks = 0;
  int errors = 0;

  logic_healthcare_system_if link ();

  logic_healthcare_system dut (
    .clock              (clock),
    .reset              (reset),
    .link               (link.slave),
    .pressureData       (pressureData),
    .bloodPH            (bloodPH),
    .bloodType          (bloodType),
    .fdSensorValue      (fdSensorValue),
    .fdFactoryValue     (fdFactoryValue),
    .factoryBaseTemp    (factoryBaseTemp),
    .factoryTempCoef    (factoryTempCoef),
    .tempSensorValue    (tempSensorValue),
    .abnormaliryWarning (abnormaliryWarning),
    .abnormaliryVector  (abnormaliryVector)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_vec(input string tag, input logic [5:0] v, input logic [2:0] w);
    check({tag, "_vec"}, 32'(abnormaliryVector), 32'(v));
    check({tag, "_warn"}, 32'(abnormaliryWarning), 32'(w));
  endtask

  task automatic check_rep(input string tag, input logic [6:0] p, input logic [6:0] q);
    check({tag, "_P"}, 32'(link.dataP), 32'(p));
    check({tag, "_Q"}, 32'(link.dataQ), 32'(q));
  endtask

  // Readings that classify as fully normal: T = 30 + 2*3 = 36.
  task automatic set_normal();
    pressureData    = 6'd30;
    bloodPH         = 4'd7;
    fdSensorValue   = 8'd10;
    fdFactoryValue  = 8'd20;
    factoryBaseTemp = 8'd30;
    factoryTempCoef = 4'd2;
    tempSensorValue = 4'd3;
  endtask

  task automatic set_link(input logic inp, input logic req, input logic cnf,
                          input logic [7:0] d, input logic [7:0] k);
    link.inputdata = inp;
    link.request   = req;
    link.confirm   = cnf;
    link.data      = d;
    link.key       = k;
  endtask

  initial begin
    // Reset held two cycles with random inputs.
    reset           = 1'b1;
    pressureData    = 6'($urandom);
    bloodPH         = 4'($urandom);
    bloodType       = 3'($urandom);
    fdSensorValue   = 8'($urandom);
    fdFactoryValue  = 8'($urandom);
    factoryBaseTemp = 8'($urandom);
    factoryTempCoef = 4'($urandom);
    tempSensorValue = 4'($urandom);
    set_link(1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom));
    step();
    step();
    check_vec("reset", 6'b000000, 3'd0);
    check_rep("reset", 7'h00, 7'h00);

    // All zero inputs: pressure low, pH 0 abnormal, T=0 hypothermia.
    reset           = 1'b0;
    pressureData    = '0;
    bloodPH         = '0;
    bloodType       = '0;
    fdSensorValue   = '0;
    fdFactoryValue  = '0;
    factoryBaseTemp = '0;
    factoryTempCoef = '0;
    tempSensorValue = '0;
    set_link(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    step();
    check_vec("zeros", 6'b011001, 3'd3);
    check_rep("zeros", 7'h00, 7'h00);

    // Normal (T=36), then fever (T=40).
    set_normal();
    step();
    check_vec("normal", 6'b000000, 3'd0);
    tempSensorValue = 4'd5;
    step();
    check_vec("fever40", 6'b000010, 3'd1);

    // Four flags: high pressure, pH 10, fall, T=30.
    pressureData    = 6'd50;
    bloodPH         = 4'd10;
    fdSensorValue   = 8'd200;
    fdFactoryValue  = 8'd100;
    factoryBaseTemp = 8'd20;
    factoryTempCoef = 4'd1;
    tempSensorValue = 4'd10;
    step();
    check_vec("four", 6'b101101, 3'd4);
    fdSensorValue = 8'd100;
    step();
    check_vec("fd_equal", 6'b101001, 3'd3);

    // Threshold edges that must stay clear: 45, pH 8, T=35.
    set_normal();
    pressureData    = 6'd45;
    bloodPH         = 4'd8;
    factoryBaseTemp = 8'd35;
    factoryTempCoef = 4'd0;
    step();
    check_vec("edge_hi_ok", 6'b000000, 3'd0);
    // 20, pH 6, T=38 also clear.
    pressureData    = 6'd20;
    bloodPH         = 4'd6;
    factoryBaseTemp = 8'd38;
    step();
    check_vec("edge_lo_ok", 6'b000000, 3'd0);
    // One step past each edge.
    pressureData    = 6'd46;
    bloodPH         = 4'd5;
    factoryBaseTemp = 8'd39;
    step();
    check_vec("edge_hi_bad", 6'b101010, 3'd3);
    pressureData    = 6'd19;
    bloodPH         = 4'd9;
    factoryBaseTemp = 8'd34;
    step();
    check_vec("edge_lo_bad", 6'b011001, 3'd3);

    // T = 255 + 15*15 = 480: fever without wrap.
    set_normal();
    factoryBaseTemp = 8'd255;
    factoryTempCoef = 4'd15;
    tempSensorValue = 4'd15;
    step();
    check_vec("t480", 6'b000010, 3'd1);

    // Basic transaction: A5 ^ 3C = 99 -> P=19, Q={1,010,000}=50.
    set_normal();
    bloodType = 3'b010;
    set_link(1'b1, 1'b0, 1'b0, 8'hA5, 8'h3C);
    step();
    check_rep("loaded", 7'h00, 7'h00);
    set_link(1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
    step();
    check_rep("send", 7'h19, 7'h50);
    for (int i = 0; i < 5; i++) begin
      // Changing inputs while in SEND must not disturb the report.
      bloodType = 3'b111;
      step();
      check_rep("hold", 7'h19, 7'h50);
    end
    set_link(1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
    step();
    check_rep("confirm", 7'h00, 7'h00);

    // Request in IDLE is ignored.
    set_link(1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
    step();
    check_rep("idle_req", 7'h00, 7'h00);

    // Load, confirm in LOADED ignored, then request+load: old pair wins.
    // Warning at request edge: pressure 50 only -> 1; Q={1,111,001}=79.
    set_link(1'b1, 1'b0, 1'b0, 8'hA5, 8'h3C);
    step();
    set_link(1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
    step();
    check_rep("loaded_cnf", 7'h00, 7'h00);
    bloodType    = 3'b111;
    pressureData = 6'd50;
    set_link(1'b1, 1'b1, 1'b0, 8'hFF, 8'h00);
    step();
    check_rep("req_wins", 7'h19, 7'h79);
    check_vec("req_wins", 6'b100000, 3'd1);

    // Reset during SEND clears everything on the next edge.
    reset = 1'b1;
    set_link(1'b1, 1'b1, 1'b0, 8'h12, 8'h34);
    step();
    check_rep("send_reset", 7'h00, 7'h00);
    check_vec("send_reset", 6'b000000, 3'd0);

    // Back in IDLE: a request alone must not send anything.
    reset = 1'b0;
    set_link(1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
    step();
    check_rep("post_reset_req", 7'h00, 7'h00);

    // Fresh load after reset encrypts the new pair: 0F^F0=FF -> P=7F,
    // Q={1,111,001}=79 (pressure still 50).
    set_link(1'b1, 1'b0, 1'b0, 8'h0F, 8'hF0);
    step();
    set_link(1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
    step();
    check_rep("reload", 7'h7F, 7'h79);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
